// File: rtl/qsys_nios2_oci_dct_packer_pkg.sv
// Shared constants and frame type for the DCT trace packer.
// Latency/backpressure: n/a (types only).
// Frame = packed symbol buffer plus symbol count.
package qsys_nios2_oci_dct_pkg;

    localparam int SYM_W = 2;
    localparam int DEPTH = 15;
    localparam int BUF_W = SYM_W * DEPTH;
    localparam int CNT_W = 4;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [BUF_W-1:0] buffer;
        logic [CNT_W-1:0] count;
    } dct_frame_t;

endpackage

// File: rtl/qsys_nios2_oci_dct_packer_outreg.sv
// One-entry valid/ready holding register for completed DCT frames.
// Latency: frame visible the cycle after load.
// Backpressure: contents hold while frame_valid & ~frame_ready; out_free tells the loader when it may load.
module qsys_nios2_oci_dct_outreg
    import qsys_nios2_oci_dct_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  dct_frame_t frame_in,
    output logic       out_free,
    output logic       frame_valid,
    input  logic       frame_ready,
    output dct_frame_t frame_out
);

    // Loading in the same cycle the sink takes the old frame gives back-to-back frames.
    assign out_free = ~frame_valid | frame_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_valid <= 1'b0;
            frame_out   <= '0;
        end else if (load) begin
            frame_valid <= 1'b1;
            frame_out   <= frame_in;
        end else if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/qsys_nios2_oci_dct_packer.sv
// Packs 2-bit trace symbols into 30-bit DCT frames with flush and end-of-test drain.
// Latency: frame_valid rises the edge the completing symbol is accepted (slot free).
// Backpressure: sym_ready drops when the accumulator is full and the output slot is busy.
module qsys_nios2_oci_dct_packer
    import qsys_nios2_oci_dct_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             sym_valid,
    input  logic [SYM_W-1:0] sym_data,
    output logic             sym_ready,
    input  logic             flush,
    input  logic             test_ending,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [BUF_W-1:0] dct_buffer,
    output logic [CNT_W-1:0] dct_count,
    output logic             test_has_ended
);

    logic [BUF_W-1:0] acc;
    logic [CNT_W-1:0] acc_cnt;
    logic             flush_pend;

    logic             accept;
    logic [BUF_W-1:0] acc_n;
    logic [CNT_W-1:0] cnt_n;
    logic             pend_n;
    logic             out_free;
    logic             xfer;
    dct_frame_t       frame_in;
    dct_frame_t       frame_out;

    assign sym_ready = (acc_cnt < DEPTH_CNT) & ~reset;
    assign accept    = sym_valid & sym_ready;

    // The symbol accepted this cycle is folded in before the transfer decision,
    // so a completing or flushed-alongside symbol lands in the outgoing frame.
    assign acc_n  = accept ? {acc[BUF_W-SYM_W-1:0], sym_data} : acc;
    assign cnt_n  = acc_cnt + {{(CNT_W-1){1'b0}}, accept};
    assign pend_n = flush_pend | flush | test_ending;

    assign xfer = out_free & ((cnt_n == DEPTH_CNT) | (pend_n & (cnt_n != '0)));

    assign frame_in.buffer = acc_n;
    assign frame_in.count  = cnt_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= '0;
            acc_cnt    <= '0;
            flush_pend <= 1'b0;
        end else if (xfer) begin
            acc        <= '0;
            acc_cnt    <= '0;
            flush_pend <= 1'b0;
        end else begin
            acc        <= acc_n;
            acc_cnt    <= cnt_n;
            // A flush with nothing buffered is dropped: empty frames are never sent.
            flush_pend <= pend_n & (cnt_n != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            test_has_ended <= 1'b0;
        end else if (test_ending && (acc_cnt == '0) && !accept && !frame_valid) begin
            test_has_ended <= 1'b1;
        end
    end

    qsys_nios2_oci_dct_outreg u_outreg (
        .clk         (clk),
        .reset       (reset),
        .load        (xfer),
        .frame_in    (frame_in),
        .out_free    (out_free),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_out   (frame_out)
    );

    assign dct_buffer = frame_out.buffer;
    assign dct_count  = frame_out.count;

endmodule
